// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register with a 2-entry skid buffer, synchronous flush and NOP output mux.
// Optional stall-cycle counter port is enabled by defining STAGE_STALL_CNT_EN.
module pipe_stage_skid #(
  parameter int unsigned       PC_W     = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    pc_plus_4_in,
  input  logic [INSTR_W-1:0] instruction_in,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    pc_plus_4_out,
`ifdef STAGE_STALL_CNT_EN
  output logic [15:0]        stall_cycles,
`endif
  output logic [INSTR_W-1:0] instruction_out
);

  logic               m_valid_q, m_valid_d;
  logic [PC_W-1:0]    m_pc_q, m_pc_d;
  logic [INSTR_W-1:0] m_ins_q, m_ins_d;
  logic               s_valid_q, s_valid_d;
  logic [PC_W-1:0]    s_pc_q, s_pc_d;
  logic [INSTR_W-1:0] s_ins_q, s_ins_d;
  logic               in_ready_q, in_ready_d;

  logic accept;
  logic issue;

  assign accept = in_valid & in_ready_q;
  assign issue  = m_valid_q & out_ready;

  always_comb begin
    m_valid_d  = m_valid_q;
    m_pc_d     = m_pc_q;
    m_ins_d    = m_ins_q;
    s_valid_d  = s_valid_q;
    s_pc_d     = s_pc_q;
    s_ins_d    = s_ins_q;

    if (flush) begin
      // Payload registers keep stale data; only the valid bits are squashed.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (issue && s_valid_q) begin
      // in_ready is low whenever the skid is full, so no accept can collide here.
      m_valid_d = 1'b1;
      m_pc_d    = s_pc_q;
      m_ins_d   = s_ins_q;
      s_valid_d = 1'b0;
    end else if (accept && (!m_valid_q || issue)) begin
      m_valid_d = 1'b1;
      m_pc_d    = pc_plus_4_in;
      m_ins_d   = instruction_in;
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_pc_d    = pc_plus_4_in;
      s_ins_d   = instruction_in;
    end else if (issue) begin
      m_valid_d = 1'b0;
    end

    in_ready_d = ~s_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid_q  <= 1'b0;
      m_pc_q     <= '0;
      m_ins_q    <= '0;
      s_valid_q  <= 1'b0;
      s_pc_q     <= '0;
      s_ins_q    <= '0;
      in_ready_q <= 1'b1;
    end else begin
      m_valid_q  <= m_valid_d;
      m_pc_q     <= m_pc_d;
      m_ins_q    <= m_ins_d;
      s_valid_q  <= s_valid_d;
      s_pc_q     <= s_pc_d;
      s_ins_q    <= s_ins_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready        = in_ready_q;
  assign out_valid       = m_valid_q;
  assign pc_plus_4_out   = m_pc_q;
  assign instruction_out = m_valid_q ? m_ins_q : NOP_WORD;

`ifdef STAGE_STALL_CNT_EN
  logic [15:0] stall_cycles_q, stall_cycles_d;

  // Counts downstream backpressure cycles; saturates and survives flush.
  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (m_valid_q && !out_ready && (stall_cycles_q != 16'hFFFF)) begin
      stall_cycles_d = stall_cycles_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_q <= 16'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Scoreboard bench for pipe_stage_skid: directed test-plan scenarios followed by random traffic.
// The reference model is a bounded FIFO of beats (capacity 2); define STAGE_STALL_CNT_EN to cover the counter.
module tb_pipe_stage_skid;

  localparam int unsigned PC_W    = 32;
  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

  typedef struct {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ins;
  } beat_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  logic [PC_W-1:0]    pc_plus_4_in;
  logic [INSTR_W-1:0] instruction_in;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    pc_plus_4_out;
  logic [INSTR_W-1:0] instruction_out;
`ifdef STAGE_STALL_CNT_EN
  logic [15:0]        stall_cycles;
  int                 exp_stall;
`endif

  pipe_stage_skid #(.PC_W(PC_W), .INSTR_W(INSTR_W), .NOP_WORD(NOP)) dut (
    .clk             (clk),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .pc_plus_4_in    (pc_plus_4_in),
    .instruction_in  (instruction_in),
    .flush           (flush),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .pc_plus_4_out   (pc_plus_4_out),
`ifdef STAGE_STALL_CNT_EN
    .stall_cycles    (stall_cycles),
`endif
    .instruction_out (instruction_out)
  );

  always #5 clk = ~clk;

  beat_t mq[$];
  int    n_vec = 0;
  int    n_err = 0;
  int    snap_cnt = 0;
  bit    active = 1'b0;
  bit    pc_zero = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT state to the model FIFO and retires issued beats.
  always @(negedge clk) begin
    snap_cnt = mq.size();
    if (active) begin
      chk("out_valid", {63'd0, out_valid}, {63'd0, snap_cnt > 0});
      chk("in_ready", {63'd0, in_ready}, {63'd0, snap_cnt < 2});
      if (snap_cnt > 0) begin
        chk("pc_out", 64'(pc_plus_4_out), 64'(mq[0].pc));
        chk("ins_out", 64'(instruction_out), 64'(mq[0].ins));
      end else begin
        chk("nop_out", 64'(instruction_out), 64'(NOP));
        if (pc_zero) chk("pc_reset", 64'(pc_plus_4_out), 64'd0);
      end
`ifdef STAGE_STALL_CNT_EN
      chk("stall_cycles", 64'(stall_cycles), 64'(exp_stall));
`endif
    end
    if (snap_cnt > 0 && out_ready) void'(mq.pop_front());
  end

  // Model update for the coming clock edge: reset > flush > accept.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      mq.delete();
      pc_zero = 1'b1;
`ifdef STAGE_STALL_CNT_EN
      exp_stall = 0;
`endif
    end else begin
`ifdef STAGE_STALL_CNT_EN
      if (snap_cnt > 0 && !out_ready && exp_stall < 16'hFFFF) exp_stall++;
`endif
      if (flush) begin
        mq.delete();
      end else if (in_valid && snap_cnt < 2) begin
        mq.push_back('{pc: pc_plus_4_in, ins: instruction_in});
        pc_zero = 1'b0;
      end
    end
  end

  task automatic drive(input bit iv, input logic [PC_W-1:0] pc, input logic [INSTR_W-1:0] ins,
                       input bit ordy, input bit fl, input bit rst);
    in_valid       = iv;
    pc_plus_4_in   = pc;
    instruction_in = ins;
    out_ready      = ordy;
    flush          = fl;
    reset          = rst;
    @(posedge clk);
    #1;
  endtask

  initial begin
    in_valid = 0; pc_plus_4_in = '0; instruction_in = '0;
    out_ready = 0; flush = 0; reset = 1;
    @(posedge clk); #1;
    drive(0, 0, 0, 0, 0, 1);
    active = 1'b1;

    // First beat and latency
    drive(1, 32'h4, 32'h2108000A, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);

    // Streaming at full rate
    for (int i = 1; i <= 8; i++) drive(1, 32'(i * 4), $urandom, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);

    // Backpressure fills main then skid, then drains
    drive(1, 32'h4, 32'hAAAA0001, 0, 0, 0);
    drive(1, 32'h8, 32'hBBBB0002, 0, 0, 0);
    drive(1, 32'hC, 32'hCCCC0003, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0, 0);

    // Flush with both entries full and a beat offered
    drive(1, 32'h4, 32'hAAAA0001, 0, 0, 0);
    drive(1, 32'h8, 32'hBBBB0002, 0, 0, 0);
    drive(1, 32'hC, 32'hCCCC0003, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);

    // Reset with skid full and flush asserted, then normal traffic
    drive(1, 32'h4, 32'hAAAA0001, 0, 0, 0);
    drive(1, 32'h8, 32'hBBBB0002, 0, 0, 0);
    drive(1, 32'hC, 32'hCCCC0003, 0, 1, 1);
    drive(0, 0, 0, 1, 0, 0);
    drive(1, 32'h40, 32'h12345678, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 0);

    // Stall counting: 5 stalled cycles, flush, then reset
    drive(1, 32'h44, 32'h0BADF00D, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 1, 0, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 3) != 0, $urandom, $urandom,
            $urandom_range(0, 2) != 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 199) == 0);
    end

    for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, 0, 0);
    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, elastic successor to the fixed IF/ID register: carries PC+4 and instruction between pipeline stages using a valid/ready handshake.
- A 2-entry skid buffer keeps full throughput while making in_ready a pure register output, so the stall path has no combinational ready chain.
- Adds synchronous flush (branch/jump squash) and NOP bubble insertion.
- Drop-in between any two pipeline stages: IF/ID, ID/EX, etc.

Parameters:
- PC_W, 32, width of the PC+4 field.
- INSTR_W, 32, width of the instruction field.
- NOP_WORD, 32'h0000_0000, value driven on instruction_out when no valid beat is presented (sll $0,$0,0).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat; registered.
- pc_plus_4_in  input  PC_W  upstream PC+4.
- instruction_in  input  INSTR_W  upstream instruction.
- flush  input  1  squash all held beats; synchronous.
- out_valid  output  1  downstream beat valid.
- out_ready  input  1  downstream accepts beat.
- pc_plus_4_out  output  PC_W  held PC+4.
- instruction_out  output  INSTR_W  held instruction, or NOP_WORD when out_valid=0.

Behaviour:
- One clock (clk); reset is synchronous and active-high, sampled on the rising edge of clk.
- Storage: main entry (m_valid, m_pc, m_ins) drives the outputs; skid entry (s_valid, s_pc, s_ins) is used only on backpressure.
- Reset values: m_valid=0, s_valid=0, in_ready=1, out_valid=0, pc_plus_4_out=0, instruction_out=NOP_WORD. Data registers clear to 0.
- Handshakes:
  - Accept occurs when in_valid & in_ready.
  - Issue occurs when out_valid & out_ready.
  - out_valid = m_valid.
  - in_ready = ~s_valid, registered.
- Latency: an accepted beat appears on the outputs the next cycle when the main entry is empty or is issued in the same cycle.
- Throughput: 1 beat/cycle with out_ready held high.
- Transitions when flush=0:
  - Accept, and main empty or issuing: load main from the inputs.
  - Accept, main full, not issuing: load skid from the inputs. in_ready goes 0 next cycle.
  - Issue with skid full: main takes skid, s_valid goes 0, in_ready goes 1 next cycle. No accept is possible that cycle because in_ready=0.
  - Issue with skid empty and no accept: m_valid goes 0.
- Order is strictly FIFO, with no loss and no duplication.
- in_valid while in_ready=0 is ignored. Upstream must hold the beat.
- Payload outputs:
  - pc_plus_4_out shows m_pc.
  - instruction_out shows m_ins when m_valid=1, otherwise NOP_WORD (output mux).
- Flush:
  - Has priority over every other event in its cycle. Next cycle m_valid=0, s_valid=0, in_ready=1.
  - A beat offered in the flush cycle is discarded.
  - An issue occurring in the flush cycle still counts as delivered.
- Reset mid-operation: identical to flush, plus data registers cleared. Reset overrides flush.
- Simultaneous issue, accept, and a held main entry with empty skid: main is replaced by the input and the skid stays empty.

Optional Feature:
- Macro STAGE_STALL_CNT_EN.
- When defined: adds output port stall_cycles [15:0].
  - Increments each cycle out_valid & ~out_ready and saturates at 16'hFFFF.
  - Reset clears it to 0. Flush does not clear it.
- When undefined: no port and no counter logic. Behaviour is otherwise identical.

Test Plan:
- Reset, then in_valid=1 with pc=0x4, ins=0x2108000A, out_ready=1 -> the next cycle out_valid=1, pc_plus_4_out=0x4, instruction_out=0x2108000A. in_ready stays 1.
- Stream 8 beats (pc=0x4..0x20) with out_ready=1 -> 8 outputs in order on consecutive cycles, no gaps.
- Backpressure:
  - Send beats A(0x4) and B(0x8) with out_ready=0 -> after B, in_ready=0 and out shows A.
  - Then out_ready=1 -> A then B on consecutive cycles, and in_ready returns to 1 the cycle after A issues.
- Flush with both entries full, with in_valid=1 and pc=0xC offered in the same cycle -> next cycle out_valid=0, instruction_out=0x00000000, in_ready=1. 0xC is never output.
- Reset asserted while the skid is full and flush=1 -> next cycle all outputs at reset values. The first beat after reset is delivered normally.
- With STAGE_STALL_CNT_EN, hold out_valid=1 and out_ready=0 for 5 cycles -> stall_cycles=5. A subsequent flush leaves it at 5, and reset clears it to 0.
